// File: rtl/button_event_decoder.sv
// Push-button front end: 2-flop synchronizer, debounce, and short/long/auto-repeat press decoding.
// Auto-repeat pulses are built only when BUTTON_AUTO_REPEAT_EN is defined; otherwise o_Repeat is 0.
module button_event_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned LONG_CYCLES     = 25000000,
    parameter int unsigned REPEAT_CYCLES   = 5000000
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Button,
    output logic o_Pressed,
    output logic o_Short_Press,
    output logic o_Long_Press,
    output logic o_Repeat
);

    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
        $error("button_event_decoder: cycle parameters must all be >= 2");
    end

    localparam int unsigned DebW  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned LongW = $clog2(LONG_CYCLES);

    localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LongW-1:0] LongLast = LongW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPressed,
        StLong
    } state_e;

    logic            r_Meta;
    logic            r_Sync;
    logic            r_Stable;
    logic [DebW-1:0] r_Deb_Count;

    state_e           r_State;
    logic [LongW-1:0] r_Hold_Count;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int unsigned RepW = $clog2(REPEAT_CYCLES);
    localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_CYCLES - 1);

    logic [RepW-1:0] r_Rep_Count;
    logic            r_Repeat;

    assign o_Repeat = r_Repeat;
`else
    assign o_Repeat = 1'b0;
`endif

    // Synchronizer and debounce: a new level is accepted after DEBOUNCE_CYCLES
    // consecutive samples that differ from the current stable level.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_Meta      <= 1'b0;
            r_Sync      <= 1'b0;
            r_Stable    <= 1'b0;
            r_Deb_Count <= '0;
        end else begin
            r_Meta <= i_Button;
            r_Sync <= r_Meta;
            if (r_Sync == r_Stable) begin
                r_Deb_Count <= '0;
            end else if (r_Deb_Count == DebLast) begin
                r_Stable    <= r_Sync;
                r_Deb_Count <= '0;
            end else begin
                r_Deb_Count <= r_Deb_Count + DebW'(1);
            end
        end
    end

    // Event FSM; release is checked first so it wins over any threshold in the same cycle.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_State       <= StIdle;
            r_Hold_Count  <= '0;
            o_Pressed     <= 1'b0;
            o_Short_Press <= 1'b0;
            o_Long_Press  <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
            r_Rep_Count   <= '0;
            r_Repeat      <= 1'b0;
`endif
        end else begin
            o_Short_Press <= 1'b0;
            o_Long_Press  <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
            r_Repeat      <= 1'b0;
`endif
            unique case (r_State)
                StIdle: begin
                    if (r_Stable) begin
                        r_State      <= StPressed;
                        o_Pressed    <= 1'b1;
                        r_Hold_Count <= '0;
                    end
                end
                StPressed: begin
                    r_Hold_Count <= r_Hold_Count + LongW'(1);
                    if (!r_Stable) begin
                        r_State       <= StIdle;
                        o_Pressed     <= 1'b0;
                        o_Short_Press <= 1'b1;
                        r_Hold_Count  <= '0;
                    end else if (r_Hold_Count == LongLast) begin
                        r_State      <= StLong;
                        o_Long_Press <= 1'b1;
                        r_Hold_Count <= '0;
`ifdef BUTTON_AUTO_REPEAT_EN
                        r_Rep_Count  <= '0;
`endif
                    end
                end
                StLong: begin
                    if (!r_Stable) begin
                        r_State   <= StIdle;
                        o_Pressed <= 1'b0;
                    end
`ifdef BUTTON_AUTO_REPEAT_EN
                    else if (r_Rep_Count == RepLast) begin
                        r_Repeat    <= 1'b1;
                        r_Rep_Count <= '0;
                    end else begin
                        r_Rep_Count <= r_Rep_Count + RepW'(1);
                    end
`endif
                end
                default: begin
                    r_State   <= StIdle;
                    o_Pressed <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Front-end stage for one raw push-button. It sits directly upstream of the clock top-level's Set/Up inputs.
- Synchronizes and debounces the button, then classifies the press. Outputs are short press, long press and auto-repeat pulses, plus a clean pressed level.
- Lets the control path distinguish a tap from a hold, and lets Up auto-increment while the button is held.
- One instance per button.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable synchronized cycles needed to accept a level change (10 ms at 25 MHz).
- LONG_CYCLES, 25000000: cycles the debounced press must last before a long press is declared (1 s).
- REPEAT_CYCLES, 5000000: auto-repeat period once long-held (200 ms).
- Constraint: all three parameters are >= 2.
- Counter widths: $clog2 of each parameter.

Ports:
- i_Clock  in  1  system clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Button  in  1  raw asynchronous button, 1 = pressed.
- o_Pressed  out  1  debounced, registered pressed level.
- o_Short_Press  out  1  one-cycle pulse on release of a press shorter than long.
- o_Long_Press  out  1  one-cycle pulse when a hold reaches LONG_CYCLES.
- o_Repeat  out  1  one-cycle pulse every REPEAT_CYCLES while long-held.

Behaviour:
- Reset (synchronous, active-high):
  - Sync flops, stable level, all counters and all outputs go to 0.
  - FSM goes to IDLE.
  - Reset overrides every other event in the same cycle.
- Synchronizer: 2 flops on i_Button; r_Sync is the second flop.
- Debounce:
  - Counter increments each cycle while r_Sync != r_Stable.
  - Counter clears to 0 in any cycle where r_Sync == r_Stable.
  - When the counter holds DEBOUNCE_CYCLES-1 and r_Sync still differs, r_Stable <= r_Sync and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles at r_Sync produces no events.
- Event FSM (runs on r_Stable, all outputs registered):
  - IDLE: o_Pressed=0. On r_Stable=1: go to PRESSED, set o_Pressed=1, clear hold counter.
  - PRESSED:
    - Hold counter increments each cycle.
    - If r_Stable=0: go to IDLE, o_Pressed=0, o_Short_Press=1 for that one cycle.
    - Else if hold counter == LONG_CYCLES-1: go to LONG, o_Long_Press=1 for one cycle, clear repeat counter.
  - LONG:
    - Repeat counter increments each cycle.
    - When it reaches REPEAT_CYCLES-1: o_Repeat=1 for one cycle, counter wraps to 0.
    - If r_Stable=0: go to IDLE, o_Pressed=0, no o_Short_Press, no o_Long_Press.
- Latency: o_Pressed rises on the (DEBOUNCE_CYCLES+3)th rising edge counted from the first edge sampling i_Button=1. Release has identical latency.
- Pulse timing:
  - o_Long_Press fires exactly LONG_CYCLES cycles after o_Pressed rises.
  - First o_Repeat fires REPEAT_CYCLES cycles after o_Long_Press, then periodically.
- Simultaneous events:
  - Release takes priority over a long/repeat threshold in the same cycle: that cycle produces the release behaviour only.
  - At most one of o_Short_Press, o_Long_Press, o_Repeat is high in any cycle.
- Reset mid-press: everything returns to 0 and IDLE. A button still held afterwards is re-synchronized and re-debounced as a fresh press (full debounce latency, hold timing restarts).
- Counters never overflow: each clears or wraps at its threshold.

Optional Feature:
- Macro: BUTTON_AUTO_REPEAT_EN.
- Defined: LONG state generates o_Repeat as above.
- Undefined:
  - Repeat counter is not built.
  - o_Repeat is tied to constant 0.
  - LONG state only waits for release.
  - All other behaviour is identical.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8):
- Hold reset 3 cycles with i_Button=1, then release reset with i_Button=1 -> o_Pressed rises on the 7th edge after reset deasserts; all pulses 0 during reset.
- i_Button high for 3 cycles then low -> o_Pressed, o_Short_Press, o_Long_Press and o_Repeat all stay 0 throughout.
- Press held 10 cycles beyond o_Pressed rise, then release -> o_Pressed falls 7 edges after i_Button falls; exactly one o_Short_Press in that same cycle; no o_Long_Press.
- Press held 50 cycles after o_Pressed -> o_Long_Press at +20; o_Repeat at +28, +36, +44; no o_Short_Press on release. With BUTTON_AUTO_REPEAT_EN undefined, o_Repeat stays 0.
- Press bouncing (1,0,1,0 single cycles) then held steady -> exactly one o_Pressed rise, 7 edges after the last transition; no extra pulses.
- i_Reset asserted during LONG -> next cycle o_Pressed=0 and state is IDLE. Button still held -> new o_Pressed after 7 edges, and the next o_Long_Press comes 20 cycles after that.
